// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshaking.
//   Stage 1 registers per-bit propagate/generate and the carry in.
//   Stage 2 forms group P/G, looks ahead across groups from cin, ripples inside
//   each group only, and registers sum/cout/ovf/zero into the output register.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_ready    input handshake (in_ready is combinational)
//   a, b, cin             operands and carry in
//   out_valid, out_ready  output handshake
//   sum, cout, ovf, zero  registered result: a+b+cin mod 2^WIDTH, carry out,
//                         signed overflow, sum-is-zero flag
module cla_pipe_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NG = WIDTH / GROUP;

    // Stage-1 registers
    logic             s1_valid;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic             s1_cin;

    // Handshake control
    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = !s1_valid || advance;

    // Stage-2 combinational lookahead
    logic [NG-1:0]    grp_p_c;
    logic [NG-1:0]    grp_g_c;
    logic [NG:0]      grp_c_c;
    logic [WIDTH-1:0] sum_c;
    logic             c_msb_c;
    logic             cout_c;
    logic             ovf_c;
    logic             zero_c;
    logic             acc_p_c;
    logic             acc_g_c;
    logic             la_c;
    logic             term_c;
    logic             rc_c;

    // Group propagate/generate: P = AND of p, G folded from the group's low bit up
    always_comb begin
        grp_p_c = '0;
        grp_g_c = '0;
        acc_p_c = 1'b0;
        acc_g_c = 1'b0;
        for (int unsigned k = 0; k < NG; k++) begin
            acc_p_c = 1'b1;
            acc_g_c = 1'b0;
            for (int unsigned j = 0; j < GROUP; j++) begin
                acc_g_c = s1_g[k*GROUP+j] | (s1_p[k*GROUP+j] & acc_g_c);
                acc_p_c = acc_p_c & s1_p[k*GROUP+j];
            end
            grp_p_c[k] = acc_p_c;
            grp_g_c[k] = acc_g_c;
        end
    end

    // Inter-group carries as flat sum-of-products of group G/P and cin
    always_comb begin
        grp_c_c    = '0;
        grp_c_c[0] = s1_cin;
        la_c       = 1'b0;
        term_c     = 1'b0;
        for (int unsigned k = 0; k < NG; k++) begin
            la_c = s1_cin;
            for (int unsigned j = 0; j <= k; j++) begin
                la_c = la_c & grp_p_c[j];
            end
            for (int unsigned j = 0; j <= k; j++) begin
                term_c = grp_g_c[j];
                for (int unsigned m = j + 1; m <= k; m++) begin
                    term_c = term_c & grp_p_c[m];
                end
                la_c = la_c | term_c;
            end
            grp_c_c[k+1] = la_c;
        end
    end

    // Per-bit carries ripple only within a group, seeded by that group's carry
    always_comb begin
        sum_c   = '0;
        c_msb_c = 1'b0;
        rc_c    = 1'b0;
        for (int unsigned k = 0; k < NG; k++) begin
            rc_c = grp_c_c[k];
            for (int unsigned j = 0; j < GROUP; j++) begin
                sum_c[k*GROUP+j] = s1_p[k*GROUP+j] ^ rc_c;
                if (k*GROUP + j == WIDTH - 1) begin
                    c_msb_c = rc_c;
                end
                rc_c = s1_g[k*GROUP+j] | (s1_p[k*GROUP+j] & rc_c);
            end
        end
    end

    assign cout_c = grp_c_c[NG];
    assign ovf_c  = grp_c_c[NG] ^ c_msb_c;
    assign zero_c = (sum_c == '0);

    // Stage-1 register: capture p/g/cin on an accepted transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_cin   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_p   <= a ^ b;
                s1_g   <= a & b;
                s1_cin <= cin;
            end
        end
    end

    // Output register: advances when empty or being taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum  <= sum_c;
                cout <= cout_c;
                ovf  <= ovf_c;
                zero <= zero_c;
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: directed corner cases plus a long
// randomized run scored against a plain-arithmetic reference model.
module tb_cla_pipe_adder;

    localparam int unsigned W = 16;
    localparam int unsigned G = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    int n_tests = 0;
    int n_fail  = 0;

    res_t exp_q[$];
    logic prev_hold = 1'b0;
    res_t prev_res;

    // Burst stimulus tables
    logic [W-1:0] op_a [8];
    logic [W-1:0] op_b [8];
    logic         op_c [8];
    res_t         op_r [8];

    cla_pipe_adder #(.WIDTH(W), .GROUP(G)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer addition, overflow from operand/result signs
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        res_t r;
        logic [W:0] full;
        full   = {1'b0, x} + {1'b0, y} + (W+1)'(c);
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (x[W-1] == y[W-1]) && (r.sum[W-1] != x[W-1]);
        r.zero = (r.sum == '0);
        return r;
    endfunction

    function automatic res_t mk(input logic [W-1:0] s, input logic c, input logic o, input logic z);
        res_t r;
        r.sum  = s;
        r.cout = c;
        r.ovf  = o;
        r.zero = z;
        return r;
    endfunction

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_result", 64'({sum, cout, ovf, zero}), 64'(prev_res));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'(1), 64'(0));
                end else begin
                    res_t r;
                    r = exp_q.pop_front();
                    check("sb_sum",  64'(sum),  64'(r.sum));
                    check("sb_cout", 64'(cout), 64'(r.cout));
                    check("sb_ovf",  64'(ovf),  64'(r.ovf));
                    check("sb_zero", 64'(zero), 64'(r.zero));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin));
            end
            prev_hold = out_valid && !out_ready;
            prev_res  = {sum, cout, ovf, zero};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = c;
    endtask

    task automatic expect_out(input string tag, input res_t r);
        check({tag, "_valid"}, 64'(out_valid), 64'(1));
        check({tag, "_sum"},   64'(sum),       64'(r.sum));
        check({tag, "_cout"},  64'(cout),      64'(r.cout));
        check({tag, "_ovf"},   64'(ovf),       64'(r.ovf));
        check({tag, "_zero"},  64'(zero),      64'(r.zero));
    endtask

    // Back-to-back burst with out_ready high: each result one edge after acceptance edge
    task automatic burst(input string tag, input int n);
        out_ready = 1'b1;
        for (int i = 0; i <= n; i++) begin
            if (i < n) drive(op_a[i], op_b[i], op_c[i]);
            else       in_valid = 1'b0;
            step();
            if (i == 0) check({tag, "_lat1"}, 64'(out_valid), 64'(0));
            else        expect_out(tag, op_r[i-1]);
        end
        step();
        check({tag, "_empty"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(1));
        check("rst_result",    64'({sum, cout, ovf, zero}), 64'(0));
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'(1));
        step();

        // Wrap to zero with carry out
        op_a[0] = 16'hFFFF; op_b[0] = 16'h0001; op_c[0] = 1'b0; op_r[0] = mk(16'h0000, 1'b1, 1'b0, 1'b1);
        burst("wrap", 1);

        // Signed overflow cases
        op_a[0] = 16'h7FFF; op_b[0] = 16'h0001; op_c[0] = 1'b0; op_r[0] = mk(16'h8000, 1'b0, 1'b1, 1'b0);
        op_a[1] = 16'h8000; op_b[1] = 16'h8000; op_c[1] = 1'b0; op_r[1] = mk(16'h0000, 1'b1, 1'b1, 1'b1);
        burst("ovf", 2);

        // Carry in plus three back-to-back results
        op_a[0] = 16'h1234; op_b[0] = 16'h4321; op_c[0] = 1'b1; op_r[0] = mk(16'h5556, 1'b0, 1'b0, 1'b0);
        op_a[1] = 16'h0001; op_b[1] = 16'h0001; op_c[1] = 1'b0; op_r[1] = mk(16'h0002, 1'b0, 1'b0, 1'b0);
        op_a[2] = 16'h00FF; op_b[2] = 16'h0001; op_c[2] = 1'b0; op_r[2] = mk(16'h0100, 1'b0, 1'b0, 1'b0);
        op_a[3] = 16'hFFFF; op_b[3] = 16'hFFFF; op_c[3] = 1'b1; op_r[3] = mk(16'hFFFF, 1'b1, 1'b0, 1'b0);
        burst("b2b", 4);

        // Backpressure: two fill the pipe, third is refused until drain
        out_ready = 1'b0;
        drive(16'h0001, 16'h0002, 1'b0);
        check("bp_rdy1", 64'(in_ready), 64'(1));
        step();
        drive(16'h0010, 16'h0020, 1'b0);
        check("bp_rdy2", 64'(in_ready), 64'(1));
        step();
        drive(16'h0100, 16'h0200, 1'b0);
        check("bp_rdy3", 64'(in_ready), 64'(0));
        check("bp_hold_sum1", 64'(sum), 64'(16'h0003));
        step();
        check("bp_rdy3b", 64'(in_ready), 64'(0));
        check("bp_hold_sum2", 64'(sum), 64'(16'h0003));
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
        check("bp_drain1", 64'(sum), 64'(16'h0030));
        step();
        check("bp_drain2", 64'(sum), 64'(16'h0300));
        check("bp_drain2_valid", 64'(out_valid), 64'(1));
        step();
        check("bp_empty", 64'(out_valid), 64'(0));

        // Asynchronous reset with two results in flight
        out_ready = 1'b0;
        drive(16'h0005, 16'h0005, 1'b0);
        step();
        drive(16'h0006, 16'h0006, 1'b0);
        step();
        in_valid = 1'b0;
        check("ar_full", 64'(out_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid_now", 64'(out_valid), 64'(0));
        check("ar_in_ready",  64'(in_ready),  64'(1));
        check("ar_sum",       64'(sum),       64'(0));
        step();
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ar_no_stale", 64'(out_valid), 64'(0));
        end

        // Randomized traffic with random backpressure
        for (int i = 0; i < 10000; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom());
            rb = W'($urandom());
            case ($urandom_range(0, 7))
                0: ra = 16'hFFFF;
                1: rb = 16'h8000;
                2: ra = 16'h7FFF;
                3: rb = ~ra;
                default: ;
            endcase
            a         = ra;
            b         = rb;
            cin       = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));
        check("final_out_valid",   64'(out_valid),    64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
